// File: rtl/ts_capture_ram.sv
// Event timestamp capture buffer: free-running counter, rising-edge event capture
// into a small RAM with a 1-cycle registered read port for the register bank.
module ts_capture_ram #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TS_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic              event_i,
  input  logic [ADDR_W-1:0] ts_addr_i,
  output logic [TS_W-1:0]   ts_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic [TS_W-1:0]   ts_cnt_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FULL
  } state_e;

  state_e            state_q;
  logic [TS_W-1:0]   mem [DEPTH];
  logic [TS_W-1:0]   ts_cnt_q;
  logic [TS_W-1:0]   ts_data_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              evt_prev_q;

  logic              evt_rise;
  logic              wr_en;
  logic [CNT_W-1:0]  count_d;

  assign evt_rise = event_i & ~evt_prev_q;
  assign wr_en    = (state_q == ARMED) & evt_rise & ~clear_i;
  assign count_d  = count_q + CNT_W'(1);

  // Control, counter and read port; the previous-event register resets high so
  // a level held through reset does not look like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ts_cnt_q   <= '0;
      ts_data_q  <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      evt_prev_q <= 1'b1;
    end else begin
      ts_cnt_q   <= ts_cnt_q + TS_W'(1);
      evt_prev_q <= event_i;
      ts_data_q  <= mem[ts_addr_i];
      if (clear_i) begin
        state_q    <= IDLE;
        wr_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable_i && (count_q < DEPTH_CNT)) state_q <= ARMED;
          end
          ARMED: begin
            if (evt_rise) begin
              wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
              count_q  <= count_d;
            end
            if (evt_rise && (count_d == DEPTH_CNT)) state_q <= FULL;
            else if (!enable_i)                      state_q <= IDLE;
          end
          FULL: begin
            if (evt_rise) overflow_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Storage is deliberately not reset; same-cycle read sees the old word.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= ts_cnt_q;
  end

  assign ts_data_o  = ts_data_q;
  assign count_o    = count_q;
  assign full_o     = (count_q == DEPTH_CNT);
  assign overflow_o = overflow_q;
  assign ts_cnt_o   = ts_cnt_q;

endmodule
